// File: rtl/image_mem_reader.sv
// Raster-scan reader from the image word memory to a valid/ready pixel stream with row/col tags.
// Define IMG_READER_MARKERS_EN to add the pix_sof / pix_eol frame markers.
module image_mem_reader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ROWS      = 16,
  parameter int unsigned COLS      = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] read_address,
  input  logic [0:DATA_W-1] read_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_row,
  output logic [7:0]        pix_col
`ifdef IMG_READER_MARKERS_EN
  ,
  output logic              pix_sof,
  output logic              pix_eol
`endif
);

  localparam int unsigned IDX_W = 8;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [IDX_W-1:0]    row_q;
  logic [IDX_W-1:0]    col_q;
  logic                busy_q;
  logic                done_q;
  logic                valid_q;
  logic [DATA_W-1:0]   data_q;
  logic [IDX_W-1:0]    pix_row_q;
  logic [IDX_W-1:0]    pix_col_q;
  logic                sof_q;
  logic                eol_q;

  logic load_c;
  logic last_c;

  // Output register is free to take a new word when empty or being drained this cycle.
  assign load_c = !valid_q || pix_ready;
  assign last_c = (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= BASE;
      row_q     <= '0;
      col_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      pix_row_q <= '0;
      pix_col_q <= '0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            addr_q  <= BASE;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (load_c) begin
            data_q    <= read_data;
            pix_row_q <= row_q;
            pix_col_q <= col_q;
            sof_q     <= (row_q == '0) && (col_q == '0);
            eol_q     <= (col_q == LAST_COL);
            valid_q   <= 1'b1;
            addr_q    <= addr_q + ADDR_W'(1);
            if (col_q == LAST_COL) begin
              col_q <= '0;
              row_q <= row_q + IDX_W'(1);
            end else begin
              col_q <= col_q + IDX_W'(1);
            end
            if (last_c) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pix_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign read_address = addr_q;
  assign pix_data     = data_q;
  assign pix_valid    = valid_q;
  assign pix_row      = pix_row_q;
  assign pix_col      = pix_col_q;
`ifdef IMG_READER_MARKERS_EN
  assign pix_sof      = sof_q;
  assign pix_eol      = eol_q;
`else
  // Marker flops are optimised away when the marker ports are absent.
  logic unused_markers;
  assign unused_markers = sof_q ^ eol_q;
`endif

endmodule
